// File: rtl/mux_pkg.sv
// Shared constants and types for the round-robin stream multiplexer.
//   MODE_FIXED / MODE_RR : values of the mode input
//   out_state_t          : occupancy of the one-entry output register
//   clog2                : index-width helper for flows without $clog2
package mux_pkg;

    localparam logic MODE_FIXED = 1'b0;
    localparam logic MODE_RR    = 1'b1;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } out_state_t;

    function automatic int unsigned clog2(input int unsigned value);
        int unsigned width;
        width = 0;
        while ((32'd1 << width) < value) begin
            width = width + 1;
        end
        return width;
    endfunction

endpackage

// File: rtl/mux_rr_stream_if.sv
// Stream bundle between NCH producers, the multiplexer and one consumer.
//   master : bench/system side (drives inputs, consumer ready)
//   slave  : multiplexer side (drives in_ready and the registered outputs)
interface mux_rr_stream_if #(
    parameter int unsigned NCH = 4,
    parameter int unsigned DW  = 8
);
    localparam int unsigned SELW = $clog2(NCH);

    logic                mode;
    logic [SELW-1:0]     sel;
    logic [NCH*DW-1:0]   in_data;
    logic [NCH-1:0]      in_valid;
    logic [NCH-1:0]      in_ready;
    logic [DW-1:0]       out_data;
    logic [SELW-1:0]     out_ch;
    logic                out_valid;
    logic                out_ready;

    modport master (
        output mode, sel, in_data, in_valid, out_ready,
        input  in_ready, out_data, out_ch, out_valid
    );

    modport slave (
        input  mode, sel, in_data, in_valid, out_ready,
        output in_ready, out_data, out_ch, out_valid
    );

endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: grants the first requester searching
// upward from (ptr+1) mod NCH with wrap.
//   req     : per-channel request
//   ptr     : last granted channel
//   gnt     : one-hot grant (zero when no request)
//   gnt_idx : index of the granted channel
module rr_arbiter #(
    parameter int unsigned NCH = 4
) (
    input  logic [NCH-1:0]           req,
    input  logic [$clog2(NCH)-1:0]   ptr,
    output logic [NCH-1:0]           gnt,
    output logic [$clog2(NCH)-1:0]   gnt_idx
);
    localparam int unsigned SELW = $clog2(NCH);
    localparam int unsigned CW   = SELW + 1;

    logic [CW-1:0]      start;
    logic [2*NCH-1:0]   dbl;
    logic [NCH-1:0]     rot;
    logic [CW-1:0]      idx;
    logic               found;

    // Rotate the doubled request vector so bit 0 is the highest-priority
    // channel, then take the lowest set bit and undo the rotation.
    always_comb begin
        start = (CW'(ptr) == CW'(NCH - 1)) ? '0 : CW'(ptr) + CW'(1);
        dbl   = {req, req} >> start;
        rot   = dbl[NCH-1:0];
        found = 1'b0;
        idx   = '0;
        for (int unsigned i = 0; i < NCH; i++) begin
            if (!found && rot[i]) begin
                found = 1'b1;
                idx   = start + CW'(i);
            end
        end
        if (idx >= CW'(NCH)) begin
            idx = idx - CW'(NCH);
        end
        gnt     = found ? (NCH'(1) << idx) : '0;
        gnt_idx = SELW'(idx);
    end

endmodule

// File: rtl/mux_rr_stream.sv
// N-channel stream multiplexer with fixed or round-robin selection and a
// one-entry registered output stage.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : mode/sel, per-channel data/valid/ready, registered output
//                data/channel/valid and consumer ready
module mux_rr_stream #(
    parameter int unsigned NCH = 4,
    parameter int unsigned DW  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    mux_rr_stream_if.slave    bus
);
    import mux_pkg::*;

    localparam int unsigned SELW = $clog2(NCH);

    out_state_t        state_q;
    out_state_t        state_d;
    logic [SELW-1:0]   ptr_q;
    logic [DW-1:0]     data_q;
    logic [SELW-1:0]   ch_q;

    logic              load_en;
    logic              xfer;
    logic [NCH-1:0]    fix_gnt;
    logic [NCH-1:0]    rr_gnt;
    logic [SELW-1:0]   rr_idx;
    logic [NCH-1:0]    gnt;
    logic [SELW-1:0]   gnt_idx;

    rr_arbiter #(.NCH(NCH)) u_arb (
        .req     (bus.in_valid),
        .ptr     (ptr_q),
        .gnt     (rr_gnt),
        .gnt_idx (rr_idx)
    );

    // Fixed-select grant; an out-of-range sel grants nothing.
    always_comb begin
        fix_gnt = '0;
        if (32'(bus.sel) < NCH) begin
            fix_gnt[bus.sel] = bus.in_valid[bus.sel];
        end
    end

    // Grant mux and handshake; in_ready is held low while in reset.
    always_comb begin
        gnt          = (bus.mode == MODE_RR) ? rr_gnt : fix_gnt;
        gnt_idx      = (bus.mode == MODE_RR) ? rr_idx : bus.sel;
        load_en      = (state_q == ST_EMPTY) | bus.out_ready;
        bus.in_ready = (load_en & rst_n) ? gnt : '0;
        xfer         = |(bus.in_valid & bus.in_ready);
    end

    // Output-stage state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: a load slot either refills the register or empties it.
    always_comb begin
        state_d = state_q;
        if (load_en) begin
            state_d = xfer ? ST_FULL : ST_EMPTY;
        end
    end

    // Output decode.
    always_comb begin
        bus.out_valid = (state_q == ST_FULL);
        bus.out_data  = data_q;
        bus.out_ch    = ch_q;
    end

    // Data, channel tag and round-robin pointer; all hold unless a word moves.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q <= '0;
            ch_q   <= '0;
            ptr_q  <= SELW'(NCH - 1);
        end else if (xfer) begin
            data_q <= bus.in_data[gnt_idx*DW +: DW];
            ch_q   <= gnt_idx;
            ptr_q  <= gnt_idx;
        end
    end

endmodule
